fetch_sequencer: RTL

- Controller between the fetch unit and the execute stage.
- Sequences fetch restart after start, branch redirect and halt.
- Drives fetch's deque and restart inputs.
- Holds one instruction in an issue register, offered to execute with a valid/accept handshake.

---
 rtl/fetch_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer: restarts fetch on start or redirect, buffers one instruction
// for execute, and stops after issuing HALT_INSN. FETCH_SEQ_PERF_EN adds a stall counter.
module fetch_sequencer #(
  parameter int unsigned          I_WIDTH   = 12,
  parameter int unsigned          A_WIDTH   = 8,
  parameter logic [I_WIDTH-1:0]   HALT_INSN = 12'hFFF,
  parameter int unsigned          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [A_WIDTH-1:0]   start_addr_i,
  input  logic [I_WIDTH-1:0]   fetch_data_i,
  input  logic [A_WIDTH-1:0]   fetch_addr_i,
  input  logic                 fetch_ready_i,
  output logic                 fetch_deque_o,
  output logic                 fetch_restart_o,
  output logic [A_WIDTH-1:0]   fetch_restart_addr_o,
  output logic                 issue_valid_o,
  output logic [I_WIDTH-1:0]   issue_data_o,
  output logic [A_WIDTH-1:0]   issue_addr_o,
  input  logic                 issue_accept_i,
  input  logic                 redirect_i,
  input  logic [A_WIDTH-1:0]   redirect_addr_i,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] issue_count_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESTART = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_HALTED  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   target_q, target_d;
  logic                 restart_q, restart_d;
  logic                 halted_q, halted_d;
  logic                 issue_valid_q, issue_valid_d;
  logic [I_WIDTH-1:0]   issue_data_q, issue_data_d;
  logic [A_WIDTH-1:0]   issue_addr_q, issue_addr_d;
  logic [CNT_WIDTH-1:0] issue_count_q, issue_count_d;
  logic                 deque_c;
  logic                 accept_c;

  // Redirect squashes the deque so the flushed cycle never loads a wrong-path instruction.
  assign accept_c = issue_valid_q & issue_accept_i;
  assign deque_c  = (state_q == S_RUN) & ~redirect_i & fetch_ready_i
                  & (~issue_valid_q | issue_accept_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_RESTART;
      S_RESTART: state_d = S_RUN;
      S_RUN: begin
        if (redirect_i)                                  state_d = S_RESTART;
        else if (deque_c && fetch_data_i == HALT_INSN)   state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (redirect_i)    state_d = S_RESTART;
        else if (accept_c) state_d = S_HALTED;
      end
      S_HALTED:  if (start_i) state_d = S_RESTART;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    target_d      = target_q;
    issue_valid_d = issue_valid_q;
    issue_data_d  = issue_data_q;
    issue_addr_d  = issue_addr_q;
    issue_count_d = issue_count_q + CNT_WIDTH'(accept_c);
    restart_d     = (state_d == S_RESTART);
    halted_d      = (state_d == S_HALTED);
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_i) target_d = start_addr_i;
      end
      S_RUN, S_DRAIN: begin
        if (redirect_i) begin
          target_d      = redirect_addr_i;
          issue_valid_d = 1'b0;
        end else if (deque_c) begin
          issue_valid_d = 1'b1;
          issue_data_d  = fetch_data_i;
          issue_addr_d  = fetch_addr_i;
        end else if (accept_c) begin
          issue_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q      <= '0;
      restart_q     <= 1'b0;
      halted_q      <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_data_q  <= '0;
      issue_addr_q  <= '0;
      issue_count_q <= '0;
    end else begin
      target_q      <= target_d;
      restart_q     <= restart_d;
      halted_q      <= halted_d;
      issue_valid_q <= issue_valid_d;
      issue_data_q  <= issue_data_d;
      issue_addr_q  <= issue_addr_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign fetch_deque_o        = deque_c;
  assign fetch_restart_o      = restart_q;
  assign fetch_restart_addr_o = target_q;
  assign issue_valid_o        = issue_valid_q;
  assign issue_data_o         = issue_data_q;
  assign issue_addr_o         = issue_addr_q;
  assign halted_o             = halted_q;
  assign issue_count_o        = issue_count_q;

`ifdef FETCH_SEQ_PERF_EN
  // Saturating count of RUN cycles where nothing leaves the issue register.
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_RUN && !accept_c && stall_q != '1) stall_d = stall_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule
